// File: rtl/memory_if.sv
// Load/store port bundle for the byte-addressable data memory.
// Carries addr_error only when MEMORY_BOUNDS_CHECK_EN is defined.
interface memory_if;
    logic [31:0] address;
    logic [31:0] wr_data;
    logic        wr_enable;
    logic [2:0]  write_length;
    logic [31:0] read_data;
`ifdef MEMORY_BOUNDS_CHECK_EN
    logic        addr_error;

    modport master (
        output address, wr_data, wr_enable, write_length,
        input  read_data, addr_error
    );
    modport slave (
        input  address, wr_data, wr_enable, write_length,
        output read_data, addr_error
    );
`else
    modport master (
        output address, wr_data, wr_enable, write_length,
        input  read_data
    );
    modport slave (
        input  address, wr_data, wr_enable, write_length,
        output read_data
    );
`endif
endinterface

// File: rtl/memory.sv
// Little-endian byte memory: async 32-bit read, sync SB/SH/SW write, unaligned OK.
// MEMORY_BOUNDS_CHECK_EN swaps modulo-DEPTH wrap for range checking plus addr_error.
module memory #(
    parameter int DEPTH = 1024
) (
    input logic     clk,
    input logic     reset,
    memory_if.slave bus
);
    localparam int ADDR_BITS = $clog2(DEPTH);

    logic [7:0]           mem_q [DEPTH];
    logic [ADDR_BITS-1:0] idx [4];
    logic [3:0]           len_be;
    logic [3:0]           in_rng;
    logic [3:0]           wr_be;
    logic                 wr_ok;
    logic [31:0]          rd_data;

    // Byte index of each lane; the narrow add wraps modulo DEPTH.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx[k] = bus.address[ADDR_BITS-1:0] + ADDR_BITS'(k);
        end
    end

    always_comb begin
        len_be = 4'b0000;
        unique case (1'b1)
            (bus.write_length == 3'd0): len_be = 4'b0001;
            (bus.write_length == 3'd1): len_be = 4'b0011;
            (bus.write_length == 3'd2): len_be = 4'b1111;
            default:                    len_be = 4'b0000;
        endcase
    end

`ifdef MEMORY_BOUNDS_CHECK_EN
    always_comb begin
        in_rng = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            in_rng[k] = ({1'b0, bus.address} + 33'(k)) < 33'(DEPTH);
        end
    end

    // Any lane out of range kills the whole write.
    assign wr_ok = bus.wr_enable && ((len_be & ~in_rng) == 4'b0000);
    assign bus.addr_error = !in_rng[3]
        || (bus.wr_enable && ((len_be & ~in_rng) != 4'b0000));
`else
    logic unused_addr;

    assign in_rng      = 4'b1111;
    assign wr_ok       = bus.wr_enable;
    assign unused_addr = ^bus.address[31:ADDR_BITS];
`endif

    assign wr_be = wr_ok ? len_be : 4'b0000;

    always_comb begin
        rd_data = 32'h0000_0000;
        for (int k = 0; k < 4; k++) begin
            rd_data[8*k +: 8] = in_rng[k] ? mem_q[idx[k]] : 8'h00;
        end
    end

    assign bus.read_data = rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) begin
                    mem_q[idx[k]] <= bus.wr_data[8*k +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_memory.sv
// Directed self-checking bench for the byte-addressable data memory.
// Expectations cover both the wrap and the MEMORY_BOUNDS_CHECK_EN builds.
module tb_memory;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    memory_if bus ();

    memory #(.DEPTH(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ne(input string tag, input logic [31:0] obs,
                            input logic [31:0] bad);
        checks++;
        assert (obs !== bad) else begin
            failures++;
            $error("FAIL %s observed=%h must differ from %h", tag, obs, bad);
        end
    endtask

    task automatic rd(input logic [31:0] a);
        bus.address = a;
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] len);
        bus.address      = a;
        bus.wr_data      = d;
        bus.write_length = len;
        bus.wr_enable    = 1'b1;
        tick();
        bus.wr_enable    = 1'b0;
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        reset            = 1'b1;
        bus.address      = 32'd0;
        bus.wr_data      = 32'd0;
        bus.wr_enable    = 1'b0;
        bus.write_length = 3'd0;
        tick();
        reset = 1'b0;

        rd(32'd0);
        check("reset_at0", bus.read_data, 32'h0000_0000);
        rd(32'd1020);
        check("reset_at1020", bus.read_data, 32'h0000_0000);

        // Write gating
        bus.address      = 32'd0;
        bus.wr_data      = 32'h89AB_CDEF;
        bus.write_length = 3'd1;
        bus.wr_enable    = 1'b0;
        tick();
        check("gate_zero", bus.read_data, 32'h0000_0000);
        check_ne("gate_ne", bus.read_data, 32'h89AB_CDEF);

        // Edge sensitivity on an unaligned word
        bus.address      = 32'd5;
        bus.wr_data      = 32'h1234_5678;
        bus.write_length = 3'd2;
        bus.wr_enable    = 1'b1;
        @(negedge clk);
        #1;
        check_ne("negedge_no_write", bus.read_data, 32'h1234_5678);
        tick();
        bus.wr_enable = 1'b0;
        check("unaligned_word", bus.read_data, 32'h1234_5678);

        // Byte writes, little-endian assembly
        wr(32'd4, 32'h12AB_CDEF, 3'd0);
        wr(32'd5, 32'h34FB_DEAD, 3'd0);
        wr(32'd6, 32'h56ED_FABD, 3'd0);
        wr(32'd7, 32'h78AD_EFAB, 3'd0);
        rd(32'd4);
        check("bytes_le", bus.read_data, 32'hABBD_ADEF);
        rd(32'd5);
        check("byte8_kept", bus.read_data, 32'h12AB_BDAD);

        // Halfword merge
        wr(32'd36, 32'h1234_ABCD, 3'd2);
        wr(32'd36, 32'h5678_EFDA, 3'd1);
        rd(32'd36);
        check("half_merge", bus.read_data, 32'h1234_EFDA);
        wr(32'd37, 32'h0000_BEEF, 3'd1);
        rd(32'd36);
        check("half_unaligned", bus.read_data, 32'h12BE_EFDA);

        // Reset beats a simultaneous write
        wr(32'd8, 32'hFFFF_FFFF, 3'd2);
        rd(32'd8);
        check("pre_reset_word", bus.read_data, 32'hFFFF_FFFF);
        bus.address      = 32'd8;
        bus.wr_data      = 32'hDEAD_BEEF;
        bus.write_length = 3'd2;
        bus.wr_enable    = 1'b1;
        reset            = 1'b1;
        tick();
        reset         = 1'b0;
        bus.wr_enable = 1'b0;
        check("reset_priority", bus.read_data, 32'h0000_0000);
        rd(32'd36);
        check("reset_clears_36", bus.read_data, 32'h0000_0000);

        // Illegal lengths write nothing
        wr(32'd16, 32'h1122_3344, 3'd2);
        wr(32'd16, 32'h5566_7788, 3'd3);
        rd(32'd16);
        check("len3_nowrite", bus.read_data, 32'h1122_3344);
        wr(32'd16, 32'h5566_7788, 3'd7);
        rd(32'd16);
        check("len7_nowrite", bus.read_data, 32'h1122_3344);

        // Top-of-memory word write
        bus.address      = 32'd1022;
        bus.wr_data      = 32'hA1B2_C3D4;
        bus.write_length = 3'd2;
        bus.wr_enable    = 1'b1;
        #1;
`ifdef MEMORY_BOUNDS_CHECK_EN
        check("addr_error_wr", 32'(bus.addr_error), 32'd1);
`endif
        tick();
        bus.wr_enable = 1'b0;
`ifdef MEMORY_BOUNDS_CHECK_EN
        rd(32'd1020);
        check("bounds_1020", bus.read_data, 32'h0000_0000);
        check("addr_error_ok", 32'(bus.addr_error), 32'd0);
        rd(32'd0);
        check("bounds_0", bus.read_data, 32'h0000_0000);
        rd(32'd1022);
        check("bounds_1022", bus.read_data, 32'h0000_0000);
        check("addr_error_rd", 32'(bus.addr_error), 32'd1);
        rd(32'd2046);
        check("bounds_high", bus.read_data, 32'h0000_0000);
        check("addr_error_high", 32'(bus.addr_error), 32'd1);
`else
        rd(32'd1022);
        check("wrap_1022", bus.read_data, 32'hA1B2_C3D4);
        rd(32'd0);
        check("wrap_0", bus.read_data, 32'h0000_A1B2);
        rd(32'd1020);
        check("wrap_1020", bus.read_data, 32'hC3D4_0000);
        rd(32'd2046);
        check("wrap_high_bits", bus.read_data, 32'hA1B2_C3D4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/memory.md
Name: memory

Overview:
- Byte-addressable, little-endian data memory for the RISC-V core. It serves load/store instructions.
- Asynchronous 32-bit read of the four bytes starting at any byte address. Synchronous write of a byte, halfword or word.
- Unaligned accesses are fully supported. The block sits behind the core's memory stage and must support SB/SH/SW.

Parameters:
- DEPTH, 1024, number of bytes of storage; must be a power of two and at least 4.
- ADDR_BITS, $clog2(DEPTH), derived; number of low address bits used to index storage.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  32  byte address for both read and write.
- wr_data  input  32  write data; low bytes used for narrow writes.
- wr_enable  input  1  write strobe, sampled on rising clk.
- write_length  input  3  0 = byte, 1 = halfword, 2 = word; 3..7 = no write.
- read_data  output  32  combinational read of bytes address..address+3.
- addr_error  output  1  present only with MEMORY_BOUNDS_CHECK_EN (see below).

Behaviour:
- Storage: DEPTH bytes, mem[0..DEPTH-1].
- Read, combinational, zero latency: read_data = {mem[a+3], mem[a+2], mem[a+1], mem[a]}, with a = address. Byte at the lowest address goes to bits [7:0] (little-endian).
- Read-after-write: read_data reflects a write immediately after the rising edge that performs it. There is no read latency and no output register.
- Write, rising clk when wr_enable=1 and reset=0:
  - length 0: mem[a] <= wr_data[7:0].
  - length 1: mem[a] <= wr_data[7:0]; mem[a+1] <= wr_data[15:8].
  - length 2: bytes a..a+3 <= wr_data[7:0], [15:8], [23:16], [31:24].
  - length 3..7: no bytes change.
- Bytes outside the written span are untouched.
- No alignment requirement: any address is legal for every length.
- Address wrap (macro undefined): each byte index is (address + k) mod DEPTH. Upper address bits are ignored.
- wr_enable=0: no state change regardless of other inputs.
- Changes to inputs between rising edges never alter storage. In particular, a falling edge performs no write.
- Reset: on a rising clk with reset=1, every byte clears to 0x00. Reset has priority over a simultaneous write, which is discarded. read_data then reads 0x00000000 at every address.
- Contents before the first reset are undefined. The bench must reset before checking, or only check inequality.
- Single write port, single read port. A write and a read to overlapping bytes in the same cycle returns old data before the edge and new data after it.

Optional Feature:
- Macro: MEMORY_BOUNDS_CHECK_EN.
- Defined:
  - Adds output addr_error, combinational.
  - addr_error = 1 when address + 3 >= DEPTH (read span out of range), or when wr_enable=1 and the write span end (address + bytes - 1) >= DEPTH.
  - Out-of-range read bytes return 0x00.
  - A write with any byte out of range is suppressed entirely; no partial write occurs.
  - No wrapping.
- Undefined:
  - No addr_error port.
  - Modulo-DEPTH wrap as above.

Test Plan:
- Write gating: reset, then wr_enable=0, address=0, wr_data=0x89ABCDEF, length 1, one rising edge -> read_data at 0 is 0x00000000 and != 0x89ABCDEF.
- Unaligned word and edge sensitivity: wr_enable=1, address=5, wr_data=0x12345678, length 2.
  - At the falling edge, read_data != 0x12345678.
  - 1 time unit after the next rising edge, read_data == 0x12345678.
- Byte writes and little-endian order: length 0, four consecutive cycles writing addresses 4, 5, 6, 7 with wr_data 0x12ABCDEF, 0x34FBDEAD, 0x56EDFABD, 0x78ADEFAB. Then set address=4 -> read_data == 0xABBDADEF.
- Halfword merge:
  - Word write 0x1234ABCD at address 36, then halfword write 0x5678EFDA at address 36 -> read at 36 == 0x1234EFDA.
  - Also check a halfword write at address 37 preserves bytes 36 and 39.
- Reset priority: write 0xFFFFFFFF at address 8, then assert reset with wr_enable=1 and wr_data=0xDEADBEEF at address 8 -> read at 8 == 0x00000000. Also write_length=3 with wr_enable=1 leaves memory unchanged.
- Bounds/wrap at DEPTH=1024:
  - Macro off: word write 0xA1B2C3D4 at 1022 -> mem[1022]=D4, mem[1023]=C3, mem[0]=B2, mem[1]=A1.
  - Macro on: same stimulus -> addr_error=1, no bytes change.
